// File: rtl/psum_acc_pkg.sv
// rtl/psum_acc_pkg.sv - shared defaults and FSM state type for the partial-sum accumulator
package psum_acc_pkg;

  localparam int DEF_ASUMDWD  = 16;
  localparam int DEF_PSUMDWD  = 24;
  localparam int DEF_ACCLENWD = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/psum_acc_if.sv
// rtl/psum_acc_if.sv - MAC-sum input and partial-sum output handshake bundle
interface psum_acc_if
  import psum_acc_pkg::*;
#(
  parameter int ASUMDWD  = DEF_ASUMDWD,
  parameter int PSUMDWD  = DEF_PSUMDWD,
  parameter int ACCLENWD = DEF_ACCLENWD
);

  logic                i_sum_valid;
  logic                o_sum_ready;
  logic [ASUMDWD-1:0]  i_sum;
  logic [ACCLENWD-1:0] i_acc_len;
  logic                i_clr;
  logic                o_psum_valid;
  logic                i_psum_ready;
  logic [PSUMDWD-1:0]  o_psum;
  logic                o_sat;

  modport master (
    output i_sum_valid, i_sum, i_acc_len, i_clr, i_psum_ready,
    input  o_sum_ready, o_psum_valid, o_psum, o_sat
  );

  modport slave (
    input  i_sum_valid, i_sum, i_acc_len, i_clr, i_psum_ready,
    output o_sum_ready, o_psum_valid, o_psum, o_sat
  );

endinterface

// File: rtl/psum_acc_satadd.sv
// rtl/psum_acc_satadd.sv - signed adder clamping to the representable range with overflow flag
module psum_acc_satadd #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y,
  output logic                ovf
);

  logic signed [W:0] full;

  // One guard bit exposes overflow; clip toward the sign of the true result
  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    ovf  = full[W] ^ full[W-1];
    if (!ovf) begin
      y = full[W-1:0];
    end else if (full[W]) begin
      y = {1'b1, {(W-1){1'b0}}};
    end else begin
      y = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - accumulates a run of MAC sums into one saturated partial sum
module psum_acc
  import psum_acc_pkg::*;
#(
  parameter int ASUMDWD  = DEF_ASUMDWD,
  parameter int PSUMDWD  = DEF_PSUMDWD,
  parameter int ACCLENWD = DEF_ACCLENWD
) (
  input logic        i_clk,
  input logic        i_rst,
  psum_acc_if.slave  bus
);

  state_e                     state_q, state_d;
  logic signed [PSUMDWD-1:0]  acc_q, acc_d;
  logic [ACCLENWD-1:0]        cnt_q, cnt_d;
  logic [ACCLENWD-1:0]        len_q, len_d;
  logic                       sat_q, sat_d;

  logic signed [ASUMDWD-1:0]  sum_s;
  logic signed [PSUMDWD-1:0]  sum_ext;
  logic signed [PSUMDWD-1:0]  add_y;
  logic                       add_ovf;
  logic [ACCLENWD-1:0]        first_len;
  logic [ACCLENWD-1:0]        cnt_inc;
  logic                       sum_ready;
  logic                       psum_valid;
  logic                       beat;
  logic                       xfer;
  logic                       load;

  assign sum_s     = bus.i_sum;
  assign sum_ext   = PSUMDWD'(sum_s);
  assign first_len = (bus.i_acc_len == '0) ? ACCLENWD'(1) : bus.i_acc_len;
  assign cnt_inc   = cnt_q + ACCLENWD'(1);

  // A held output blocks new beats unless the consumer drains it this same cycle
  assign sum_ready  = !i_rst && !bus.i_clr && ((state_q != OUT) || bus.i_psum_ready);
  assign psum_valid = !i_rst && !bus.i_clr && (state_q == OUT);
  assign beat       = bus.i_sum_valid && sum_ready;
  assign xfer       = psum_valid && bus.i_psum_ready;
  assign load       = beat && ((state_q == IDLE) || ((state_q == OUT) && xfer));

  assign bus.o_sum_ready  = sum_ready;
  assign bus.o_psum_valid = psum_valid;
  assign bus.o_psum       = i_rst ? '0 : acc_q;
  assign bus.o_sat        = !i_rst && sat_q && (state_q == OUT);

  psum_acc_satadd #(.W(PSUMDWD)) u_satadd (
    .a   (acc_q),
    .b   (sum_ext),
    .y   (add_y),
    .ovf (add_ovf)
  );

  // Next-state and datapath update; a first beat always restarts acc/cnt/len/sat
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    if (bus.i_clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      acc_d   = sum_ext;
      cnt_d   = ACCLENWD'(1);
      len_d   = first_len;
      sat_d   = 1'b0;
      state_d = (first_len == ACCLENWD'(1)) ? OUT : ACC;
    end else begin
      case (state_q)
        ACC: begin
          if (beat) begin
            acc_d = add_y;
            sat_d = sat_q | add_ovf;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = OUT;
            end
          end
        end
        OUT: begin
          if (xfer) begin
            state_d = IDLE;
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register; reset outranks clear and any beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= ACCLENWD'(1);
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_psum_acc.sv
// tb/tb_psum_acc.sv - randomized and directed checks of psum_acc against a queue-based model
module tb_psum_acc;

  localparam int AW   = 12;
  localparam int PW   = 12;
  localparam int LW   = 8;
  localparam int PMAX = 2047;
  localparam int PMIN = -2048;

  typedef struct {
    int psum;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  psum_acc_if #(.ASUMDWD(AW), .PSUMDWD(PW), .ACCLENWD(LW)) bus ();

  psum_acc #(.ASUMDWD(AW), .PSUMDWD(PW), .ACCLENWD(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];
  int   g_cnt = 0;
  int   g_len = 1;
  int   g_sum = 0;
  bit   g_sat = 1'b0;

  bit      obs_ready;
  bit      obs_valid;
  longint  obs_psum;
  bit      obs_sat;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample just after, check, then advance the model
  task automatic cycle(input bit v, input int s, input int len, input bit clr,
                       input bit pr, input bit r);
    bit   pending;
    bit   exp_ready;
    exp_t e;
    @(negedge clk);
    bus.i_sum_valid  = v;
    bus.i_sum        = AW'(s);
    bus.i_acc_len    = LW'(len);
    bus.i_clr        = clr;
    bus.i_psum_ready = pr;
    rst              = r;
    #1;
    obs_ready = bus.o_sum_ready;
    obs_valid = bus.o_psum_valid;
    obs_psum  = longint'($signed(bus.o_psum));
    obs_sat   = bus.o_sat;

    pending   = (exp_q.size() > 0);
    exp_ready = !r && !clr && (!pending || pr);
    chk("sum_ready", obs_ready, exp_ready);
    chk("psum_valid", obs_valid, !r && !clr && pending);
    if (r) begin
      chk("rst_psum", obs_psum, 0);
      chk("rst_sat", obs_sat, 0);
    end else if (pending && !clr) begin
      chk("psum", obs_psum, exp_q[0].psum);
      chk("sat", obs_sat, exp_q[0].sat);
    end

    if (r || clr) begin
      exp_q.delete();
      g_cnt = 0;
    end else begin
      if (pending && pr) void'(exp_q.pop_front());
      if (v && exp_ready) begin
        if (g_cnt == 0) begin
          g_len = (len == 0) ? 1 : len;
          g_sum = s;
          g_sat = 1'b0;
        end else begin
          g_sum = g_sum + s;
          if (g_sum > PMAX) begin g_sum = PMAX; g_sat = 1'b1; end
          if (g_sum < PMIN) begin g_sum = PMIN; g_sat = 1'b1; end
        end
        g_cnt++;
        if (g_cnt == g_len) begin
          e.psum = g_sum;
          e.sat  = g_sat;
          exp_q.push_back(e);
          g_cnt = 0;
        end
      end
    end
  endtask

  task automatic idle(input bit pr);
    cycle(1'b0, 0, 1, 1'b0, pr, 1'b0);
  endtask

  initial begin
    int r031[2];
    bus.i_sum_valid  = 1'b0;
    bus.i_sum        = '0;
    bus.i_acc_len    = '0;
    bus.i_clr        = 1'b0;
    bus.i_psum_ready = 1'b1;

    cycle(1'b1, 5, 1, 1'b1, 1'b1, 1'b1);
    chk("reset_ready", obs_ready, 0);
    cycle(1'b0, 0, 1, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("idle_valid", obs_valid, 0);

    // Four back-to-back beats
    cycle(1'b1, 10, 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, -3, 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 7, 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 100, 4, 1'b0, 1'b1, 1'b0);
    chk("len4_not_early", obs_valid, 0);
    idle(1'b1);
    chk("len4_valid", obs_valid, 1);
    chk("len4_psum", obs_psum, 114);
    chk("len4_sat", obs_sat, 0);

    // len 0 acts as 1; outputs back-to-back
    cycle(1'b1, -480, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 900, 1, 1'b0, 1'b1, 1'b0);
    r031[0] = int'(obs_psum);
    chk("len0_ready", obs_ready, 1);
    idle(1'b1);
    r031[1] = int'(obs_psum);
    chk("len0_psum", r031[0], -480);
    chk("len1_psum", r031[1], 900);

    // Positive then negative saturation
    repeat (3) cycle(1'b1, 900, 3, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("satp_psum", obs_psum, 2047);
    chk("satp_sat", obs_sat, 1);
    cycle(1'b1, -2000, 2, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, -100, 2, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("satn_psum", obs_psum, -2048);
    chk("satn_sat", obs_sat, 1);

    // Backpressure holds the output and stalls input
    cycle(1'b1, 42, 1, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      cycle(1'b1, 7, 1, 1'b0, 1'b0, 1'b0);
      chk("bp_psum", obs_psum, 42);
      chk("bp_ready", obs_ready, 0);
    end
    cycle(1'b1, 5, 1, 1'b0, 1'b1, 1'b0);
    chk("bp_release_ready", obs_ready, 1);
    idle(1'b1);
    chk("bp_next_psum", obs_psum, 5);

    // Clear mid-accumulation drops the colliding beat
    cycle(1'b1, 1, 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1, 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 9, 4, 1'b1, 1'b1, 1'b0);
    chk("clr_ready", obs_ready, 0);
    cycle(1'b1, 1, 2, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 2, 2, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("clr_after_psum", obs_psum, 3);

    // Reset in ACC, in OUT, and together with clear and a beat
    cycle(1'b1, 1, 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1, 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1, 4, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("rst_acc_idle", obs_valid, 0);
    cycle(1'b1, 3, 1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("rst_out_idle", obs_valid, 0);
    cycle(1'b1, 6, 1, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    chk("rst_clr_idle", obs_valid, 0);

    // Longest accumulation completes without counter wrap
    repeat (255) cycle(1'b1, 1, 255, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("len255_psum", obs_psum, 255);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) - 2048
                                      : int'($urandom_range(0, 200)) - 100;
      cycle($urandom_range(0, 9) < 7, s, int'($urandom_range(0, 5)),
            $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
